// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-compatible bus responder with DDRAM image, AC, busy flag and host read port
module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 4,
  parameter int HOME_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [6:0] disp_addr,
  output logic [7:0] disp_char,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       busy,
  output logic       protocol_err
);
  logic [7:0] mem [80];
  logic e_q, fall, acc, instr, dwr, rd_step, clr, home, mem_we;
  logic [6:0] ac_q, ac_d, ac_inc, ac_dec, ac_set, a, idx, fill_q, fill_d, mem_wa;
  logic [7:0] mem_wd, out_q, out_d, dc_q, dc_d;
  logic [15:0] cnt_q, cnt_d;
  logic id_q, id_d, s_q, s_d, d_q, d_d, c_q, c_d, b_q, b_d;
  logic dl_q, dl_d, n_q, n_d, f_q, f_d, cg_q, cg_d, fa_q, fa_d, oe_q, oe_d, err_q, err_d;
  assign fall    = e_q & ~lcd_e;
  assign busy    = (cnt_q != 16'd0) | fa_q;
  assign acc     = fall & ~busy & ~lcd_rw;
  assign instr   = acc & ~lcd_rs;
  assign dwr     = acc & lcd_rs;
  assign rd_step = fall & ~busy & lcd_rw & lcd_rs;
  assign clr     = instr & (lcd_data_in == 8'h01);
  assign home    = instr & (lcd_data_in[7:1] == 7'h01);
  assign a       = lcd_data_in[6:0];
  // AC lives in two 40-cell windows: 0x00-0x27 and 0x40-0x67
  assign ac_inc  = (ac_q == 7'h27) ? 7'h40 : (ac_q == 7'h67) ? 7'h00 : ac_q + 7'd1;
  assign ac_dec  = (ac_q == 7'h00) ? 7'h67 : (ac_q == 7'h40) ? 7'h27 : ac_q - 7'd1;
  assign ac_set  = (a >= 7'h68) ? 7'h00 : (a >= 7'h28 && a < 7'h40) ? 7'h40 : a;
  assign idx     = ac_q[6] ? ac_q - 7'd24 : ac_q;
  always_comb begin
    ac_d = ac_q;
    id_d = id_q;
    s_d = s_q;
    d_d = d_q;
    c_d = c_q;
    b_d = b_q;
    dl_d = dl_q;
    n_d = n_q;
    f_d = f_q;
    cg_d = cg_q;
    if (instr) begin
      if (lcd_data_in[7]) begin
        cg_d = 1'b0;
        ac_d = ac_set;
      end else if (lcd_data_in[6]) cg_d = 1'b1;
      else if (lcd_data_in[5]) {dl_d, n_d, f_d} = lcd_data_in[4:2];
      else if (lcd_data_in[4]) ac_d = lcd_data_in[3] ? ac_q : lcd_data_in[2] ? ac_inc : ac_dec;
      else if (lcd_data_in[3]) {d_d, c_d, b_d} = lcd_data_in[2:0];
      else if (lcd_data_in[2]) {id_d, s_d} = lcd_data_in[1:0];
      else if (lcd_data_in[1]) ac_d = 7'h00;
      else if (lcd_data_in[0]) begin
        ac_d = 7'h00;
        id_d = 1'b1;
      end
    end
    if (dwr | rd_step) ac_d = id_q ? ac_inc : ac_dec;
  end
  always_comb begin
    cnt_d  = clr ? 16'(CLEAR_CYCLES) : home ? 16'(HOME_CYCLES) : acc ? 16'(BUSY_CYCLES)
           : cnt_q - {15'd0, cnt_q != 16'd0};
    fa_d   = clr | (fa_q & (fill_q != 7'd79));
    fill_d = clr ? 7'd0 : fa_q ? fill_q + 7'd1 : fill_q;
    mem_we = fa_q | (dwr & ~cg_q);
    mem_wa = fa_q ? fill_q : idx;
    mem_wd = fa_q ? 8'h20 : lcd_data_in;
    oe_d   = lcd_e & lcd_rw;
    out_d  = ~oe_d ? 8'h00 : ~lcd_rs ? {busy, ac_q} : busy ? 8'h00 : mem[idx];
    err_d  = fall & busy & (~lcd_rw | lcd_rs);
    dc_d   = (disp_addr > 7'd79) ? 8'h00 : mem[disp_addr];
  end
  always_ff @(posedge clk) if (!rst && mem_we) mem[mem_wa] <= mem_wd;
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= 1'b0;
      ac_q <= 7'h00;
      {id_q, s_q, d_q, c_q, b_q} <= 5'b10000;
      {dl_q, n_q, f_q, cg_q} <= 4'b0000;
      cnt_q <= 16'd0;
      fa_q <= 1'b0;
      fill_q <= 7'd0;
      out_q <= 8'h00;
      oe_q <= 1'b0;
      err_q <= 1'b0;
      dc_q <= 8'h00;
    end else begin
      e_q <= lcd_e;
      ac_q <= ac_d;
      {id_q, s_q, d_q, c_q, b_q} <= {id_d, s_d, d_d, c_d, b_d};
      {dl_q, n_q, f_q, cg_q} <= {dl_d, n_d, f_d, cg_d};
      cnt_q <= cnt_d;
      fa_q <= fa_d;
      fill_q <= fill_d;
      out_q <= out_d;
      oe_q <= oe_d;
      err_q <= err_d;
      dc_q <= dc_d;
    end
  end
  assign lcd_data_out = out_q;
  assign lcd_data_oe  = oe_q;
  assign disp_char    = dc_q;
  assign cursor_addr  = ac_q;
  assign disp_on      = d_q;
  assign protocol_err = err_q;
endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Synthesizable HD44780-compatible responder that sits on the far end of the 8-bit character-LCD bus (lcd_e/lcd_rs/lcd_rw/lcd_data).
- Decodes instruction and data writes, maintains an 80-byte DDRAM image, address counter (AC) and display flags, and answers busy-flag and data reads.
- Exposes a host-side read port so the LCD controller can be checked in simulation, or its output mirrored on another display, without a physical panel.

Parameters:
- BUSY_CYCLES, 4, clk cycles busy after any accepted write except clear and home.
- HOME_CYCLES, 40, busy cycles after return-home.
- CLEAR_CYCLES, 160, busy cycles after clear-display; must be >= 80.

Ports:
- clk  in  1  system clock; all bus inputs are synchronous to it.
- rst  in  1  synchronous, active-high reset.
- lcd_e  in  1  bus enable strobe.
- lcd_rs  in  1  0 = instruction, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_data_in  in  8  bus data from controller.
- lcd_data_out  out  8  read data.
- lcd_data_oe  out  1  high while this block drives the bus.
- disp_addr  in  7  host linear index, 0-79 (0-39 = line 1, 40-79 = line 2).
- disp_char  out  8  DDRAM byte at disp_addr; 1-cycle latency; 0x00 if index > 79.
- cursor_addr  out  7  current AC.
- disp_on  out  1  D bit of display on/off.
- busy  out  1  busy flag.
- protocol_err  out  1  one-cycle pulse on an access that violates the rules below.

Behaviour:
- Reset (synchronous, rst high at posedge clk):
  - AC = 0x00, I/D = 1, S = 0, D = C = B = 0, DL/N/F = 0, cgram_mode = 0, busy = 0.
  - Busy counter = 0, lcd_data_out = 0x00, lcd_data_oe = 0, protocol_err = 0, disp_char = 0x00.
  - DDRAM contents are not cleared by reset.
  - rst during a clear fill aborts the fill immediately: cells already written stay 0x20, the rest are unchanged.
- Strobe detection:
  - e_q is lcd_e registered on clk.
  - Falling edge = e_q & ~lcd_e.
  - rs, rw and data are sampled on the falling-edge cycle; the write takes effect in that cycle.
- Write while busy = 1: ignored, and protocol_err pulses.
- Instruction writes (rs = 0, rw = 0), decoded by highest set bit:
  - 0x01 clear: start an 80-cycle fill writing 0x20 to index 0..79, one per cycle. AC = 0, I/D = 1. busy = CLEAR_CYCLES.
  - 0x02-0x03 home: AC = 0. busy = HOME_CYCLES.
  - 0x04-0x07 entry mode: I/D = bit1, S = bit0. S is stored but display shift is not modelled.
  - 0x08-0x0F display control: D = bit2, C = bit1, B = bit0.
  - 0x10-0x1F shift: if bit3 = 0, step AC right when bit2 = 1 and left when bit2 = 0, using the wrap rules below. If bit3 = 1, no AC change.
  - 0x20-0x3F function set: DL = bit4, N = bit3, F = bit2.
  - 0x40-0x7F set CGRAM address: cgram_mode = 1. Later data writes are discarded, but AC still steps.
  - 0x80-0xFF set DDRAM address: cgram_mode = 0, AC = data[6:0], with these clamps:
    - 0x28-0x3F becomes 0x40.
    - 0x68-0x7F becomes 0x00.
  - Every instruction except clear and home loads busy = BUSY_CYCLES.
- Data write (rs = 1, rw = 0):
  - DDRAM[AC] = data unless cgram_mode = 1.
  - AC steps per I/D.
  - busy = BUSY_CYCLES.
- AC wrap rules:
  - Increment: 0x27 → 0x40, 0x67 → 0x00.
  - Decrement: 0x00 → 0x67, 0x40 → 0x27.
  - Linear index = AC for 0x00-0x27, AC − 0x40 + 40 for 0x40-0x67.
- Busy counter:
  - Decrements once per clk.
  - busy = (counter != 0).
  - A clear must both finish the fill and reach 0 before busy drops.
- Reads (rw = 1), driven while lcd_e = 1:
  - lcd_data_oe = 1 from the cycle after lcd_e rises until the cycle lcd_e falls.
  - rs = 0: lcd_data_out = {busy, AC}. Legal while busy.
  - rs = 1: lcd_data_out = DDRAM[AC]. On the falling edge, AC steps per I/D with no busy load.
  - A data read while busy returns 0x00 and pulses protocol_err.
- Host port:
  - disp_char is registered from the DDRAM second read port.
  - If the bus writes the same cell in the same cycle, disp_char returns the old value.

Test Plan:
- Reset, then init writes 0x3C, 0x0C, 0x06, 0x80, each held past busy, then data 0x41 → DDRAM[0] = 0x41, cursor_addr = 0x01, disp_on = 1, busy high for exactly 4 cycles after each write.
- 0x80 | 0x27, then data 0x31, 0x32 → index 39 = 0x31, index 40 = 0x32, AC = 0x41; repeat with 0x80 | 0x67 → wraps to 0x00.
- Entry 0x04 (decrement), set 0x80, write 0x58 → DDRAM[0] = 0x58, AC = 0x67.
- 0x01 clear → busy = 1 for 160 cycles; afterwards all 80 disp_char reads = 0x20 and AC = 0. A write at cycle 10 is ignored and pulses protocol_err.
- Status read (rs = 0, rw = 1) with lcd_e high during clear → lcd_data_out = 0x80 and oe = 1. After busy clears, a status read returns 0x00.
- rst asserted at fill cycle 30 → indices 0-29 = 0x20, indices 30-79 retain prior data, busy = 0 on the next cycle.
